ncpu32k_d_mmu_assoc: RTL and testbench

Next-generation data MMU: a set-associative DTLB with parametrised sets, ways and page size, plus a hardware flush sequencer and an uncached-attribute output. It sits between the LSU (dbus) and the D-cache (dcache) and translates each command in one registered lookup stage. It raises TLB-miss or page-fault exceptions and captures the faulting virtual address. Software maintains the TLB through the DTLBL/DTLBH MSRs, addressed by {way,set}.

---
 rtl/ncpu32k_d_mmu_assoc_if.sv | 30 +++
 rtl/ncpu32k_d_mmu_assoc.sv | 248 ++++++++++++++++++++++++
 tb/tb_ncpu32k_d_mmu_assoc.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ncpu32k_d_mmu_assoc_if.sv
`default_nettype none
//==============================================================================
// Module  : ncpu32k_d_mmu_assoc_if
// Brief   : Command/response bus between LSU, data MMU and D-cache.
//           The master issues commands and consumes responses.
// Revision: 1.0 - initial release
//==============================================================================
interface ncpu32k_d_mmu_assoc_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic        cmd_we;
    logic        cmd_nc;
    logic [31:0] din;
    logic        valid;
    logic        ready;
    logic [31:0] dout;

    modport master (
        output cmd_valid, cmd_addr, cmd_size, cmd_we, cmd_nc, din, ready,
        input  cmd_ready, valid, dout
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_size, cmd_we, cmd_nc, din, ready,
        output cmd_ready, valid, dout
    );
endinterface
`default_nettype wire

// File: rtl/ncpu32k_d_mmu_assoc.sv
`default_nettype none
//==============================================================================
// Module  : ncpu32k_d_mmu_assoc
// Brief   : Set-associative data MMU. One registered lookup stage between the
//           LSU and the D-cache, TLB-miss / page-fault detection, MSR access to
//           the TLB by {way,set} and a hardware invalidate-all sequencer.
// Revision: 1.0 - initial release
//==============================================================================
module ncpu32k_d_mmu_assoc #(
    parameter int TLB_NSETS_LOG2 = 5,
    parameter int TLB_NWAYS_LOG2 = 1,
    parameter int PAGE_SHIFT     = 13
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    ncpu32k_d_mmu_assoc_if.slave                   dbus,
    ncpu32k_d_mmu_assoc_if.master                  dcache,
    output logic                                   exp_dmm_tlb_miss,
    output logic                                   exp_dmm_page_fault,
    output logic [31:0]                            exp_dmm_vaddr,
    input  logic                                   msr_psr_dmme,
    input  logic                                   msr_psr_rm,
    output logic [31:0]                            msr_dmmid,
    input  logic [TLB_NWAYS_LOG2+TLB_NSETS_LOG2-1:0] msr_dmm_tlbl_idx,
    input  logic [31:0]                            msr_dmm_tlbl_nxt,
    input  logic                                   msr_dmm_tlbl_we,
    output logic [31:0]                            msr_dmm_tlbl,
    input  logic [TLB_NWAYS_LOG2+TLB_NSETS_LOG2-1:0] msr_dmm_tlbh_idx,
    input  logic [31:0]                            msr_dmm_tlbh_nxt,
    input  logic                                   msr_dmm_tlbh_we,
    output logic [31:0]                            msr_dmm_tlbh,
    input  logic                                   tlb_flush_req,
    output logic                                   tlb_flush_busy
);

    localparam int c_NSETS = 1 << TLB_NSETS_LOG2;
    localparam int c_NWAYS = 1 << TLB_NWAYS_LOG2;
    localparam int c_IDX_W = TLB_NWAYS_LOG2 + TLB_NSETS_LOG2;
    localparam int c_NENT  = 1 << c_IDX_W;
    localparam logic [TLB_NSETS_LOG2-1:0] c_FLUSH_LAST = '1;
    localparam logic [2:0] c_NWAYS_ID = 3'(TLB_NWAYS_LOG2);
    localparam logic [2:0] c_NSETS_ID = 3'(TLB_NSETS_LOG2);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [TLB_NSETS_LOG2-1:0] r_flush_cnt;

    logic [31:0] r_tlbl [c_NENT];
    logic [31:0] r_tlbh [c_NENT];
    logic [31:0] r_msr_tlbl;
    logic [31:0] r_msr_tlbh;

    logic        r_stage_v;
    logic [31:0] r_vaddr;
    logic [31:0] r_din;
    logic [2:0]  r_size;
    logic        r_we;
    logic        r_dmme;
    logic        r_rm;
    logic [31:0] r_exp_vaddr;

    logic                      w_accept;
    logic                      w_advance;
    logic                      w_cmd_ready;
    logic                      w_cmd_valid;
    logic [TLB_NSETS_LOG2-1:0] w_lkp_set;
    logic [c_NWAYS-1:0]        w_hit;
    logic [31:0]               w_way_h [c_NWAYS];
    logic                      w_hit_any;
    logic [31:0]               w_hit_h;
    logic                      w_deny;
    logic                      w_miss;
    logic                      w_fault;
    logic                      w_unused;

    assign w_lkp_set = dbus.cmd_addr[PAGE_SHIFT +: TLB_NSETS_LOG2];
    assign w_accept  = dbus.cmd_valid & w_cmd_ready;
    assign w_advance = (w_cmd_valid & dcache.cmd_ready) | w_miss | w_fault;

    // Flush state register and set counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + 1'b1 : '0;
        end
    end

    // Next state and handshake: flush only starts with an empty stage
    always_comb begin
        w_state_nxt    = r_state;
        tlb_flush_busy = 1'b0;
        w_cmd_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = ~tlb_flush_req & (~r_stage_v | w_advance);
                if (tlb_flush_req && !r_stage_v) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                tlb_flush_busy = 1'b1;
                if (r_flush_cnt == c_FLUSH_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // TLB storage: the flush sequencer owns the arrays while running, so
    // MSR writes only land when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NENT; i++) begin
                r_tlbl[i] <= '0;
                r_tlbh[i] <= '0;
            end
        end else if (r_state == ST_FLUSH) begin
            for (int w = 0; w < c_NWAYS; w++) begin
                r_tlbl[(c_IDX_W'(w) << TLB_NSETS_LOG2) | c_IDX_W'(r_flush_cnt)] <= '0;
            end
        end else begin
            if (msr_dmm_tlbl_we) r_tlbl[msr_dmm_tlbl_idx] <= msr_dmm_tlbl_nxt;
            if (msr_dmm_tlbh_we) r_tlbh[msr_dmm_tlbh_idx] <= msr_dmm_tlbh_nxt;
        end
    end

    // MSR read port: registered, sees pre-write contents on a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msr_tlbl <= '0;
            r_msr_tlbh <= '0;
        end else begin
            r_msr_tlbl <= r_tlbl[msr_dmm_tlbl_idx];
            r_msr_tlbh <= r_tlbh[msr_dmm_tlbh_idx];
        end
    end

    // Lookup stage: capture the command on accept, drop it once it leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_v <= 1'b0;
            r_vaddr   <= '0;
            r_din     <= '0;
            r_size    <= '0;
            r_we      <= 1'b0;
            r_dmme    <= 1'b0;
            r_rm      <= 1'b0;
        end else if (w_accept) begin
            r_stage_v <= 1'b1;
            r_vaddr   <= dbus.cmd_addr;
            r_din     <= dbus.din;
            r_size    <= dbus.cmd_size;
            r_we      <= dbus.cmd_we;
            r_dmme    <= msr_psr_dmme;
            r_rm      <= msr_psr_rm;
        end else if (w_advance) begin
            r_stage_v <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < c_NWAYS; gi++) begin : g_way
            localparam logic [c_IDX_W-1:0] c_WAY_BASE = c_IDX_W'(gi) << TLB_NSETS_LOG2;
            logic [31:0]        r_ent_l;
            logic [31:0]        r_ent_h;
            logic [c_IDX_W-1:0] w_idx;
            logic               w_unused_lo;

            assign w_idx = c_WAY_BASE | c_IDX_W'(w_lkp_set);

            // Read this way of the indexed set together with the command
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ent_l <= '0;
                    r_ent_h <= '0;
                end else if (w_accept) begin
                    r_ent_l <= r_tlbl[w_idx];
                    r_ent_h <= r_tlbh[w_idx];
                end
            end

            assign w_hit[gi]   = r_ent_l[0] & (r_ent_l[31:PAGE_SHIFT] == r_vaddr[31:PAGE_SHIFT]);
            assign w_way_h[gi] = r_ent_h;
            assign w_unused_lo = ^r_ent_l[PAGE_SHIFT-1:1];
        end
    endgenerate

    // Hit select: scanning downward lets the lowest matching way win
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_h   = '0;
        for (int w = c_NWAYS - 1; w >= 0; w--) begin
            if (w_hit[w]) begin
                w_hit_any = 1'b1;
                w_hit_h   = w_way_h[w];
            end
        end
    end

    // Permission check: root mode uses RW/RR, user mode UW/UR
    always_comb begin
        w_deny = 1'b0;
        if (r_rm) w_deny = r_we ? ~w_hit_h[5] : ~w_hit_h[6];
        else      w_deny = r_we ? ~w_hit_h[3] : ~w_hit_h[4];
    end

    assign w_miss      = r_stage_v & r_dmme & ~w_hit_any;
    assign w_fault     = r_stage_v & r_dmme & w_hit_any & w_deny;
    assign w_cmd_valid = r_stage_v & ~w_miss & ~w_fault;

    // Faulting address is held until the next exception
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_exp_vaddr <= '0;
        else if (w_miss | w_fault) r_exp_vaddr <= r_vaddr;
    end

    assign dbus.cmd_ready   = w_cmd_ready;
    assign dbus.valid       = dcache.valid;
    assign dbus.dout        = dcache.dout;
    assign dcache.ready     = dbus.ready;
    assign dcache.cmd_valid = w_cmd_valid;
    assign dcache.cmd_addr  = r_dmme ? {w_hit_h[31:PAGE_SHIFT], r_vaddr[PAGE_SHIFT-1:0]} : r_vaddr;
    assign dcache.cmd_size  = r_size;
    assign dcache.cmd_we    = r_we;
    assign dcache.cmd_nc    = r_dmme & w_hit_h[7];
    assign dcache.din       = r_din;

    assign exp_dmm_tlb_miss   = w_miss;
    assign exp_dmm_page_fault = w_fault;
    assign exp_dmm_vaddr      = r_exp_vaddr;
    assign msr_dmmid          = {26'b0, c_NWAYS_ID, c_NSETS_ID};
    assign msr_dmm_tlbl       = r_msr_tlbl;
    assign msr_dmm_tlbh       = r_msr_tlbh;

    // The LSU never supplies a cacheability hint; only the TLB does
    assign w_unused = dbus.cmd_nc;

endmodule
`default_nettype wire

// File: tb/tb_ncpu32k_d_mmu_assoc.sv
`default_nettype none
//==============================================================================
// Module  : tb_ncpu32k_d_mmu_assoc
// Brief   : Directed self-checking bench for the set-associative data MMU
//           (S=5, W=1, 8 KiB pages).
// Revision: 1.0 - initial release
//==============================================================================
module tb_ncpu32k_d_mmu_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exp_dmm_tlb_miss, exp_dmm_page_fault;
    logic [31:0] exp_dmm_vaddr, msr_dmmid;
    logic        msr_psr_dmme, msr_psr_rm;
    logic [5:0]  tlbl_idx, tlbh_idx;
    logic [31:0] tlbl_nxt, tlbh_nxt, msr_dmm_tlbl, msr_dmm_tlbh;
    logic        tlbl_we, tlbh_we;
    logic        tlb_flush_req, tlb_flush_busy;
    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_flush;

    ncpu32k_d_mmu_assoc_if dbus ();
    ncpu32k_d_mmu_assoc_if dcache ();

    ncpu32k_d_mmu_assoc #(
        .TLB_NSETS_LOG2 (5),
        .TLB_NWAYS_LOG2 (1),
        .PAGE_SHIFT     (13)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dbus               (dbus),
        .dcache             (dcache),
        .exp_dmm_tlb_miss   (exp_dmm_tlb_miss),
        .exp_dmm_page_fault (exp_dmm_page_fault),
        .exp_dmm_vaddr      (exp_dmm_vaddr),
        .msr_psr_dmme       (msr_psr_dmme),
        .msr_psr_rm         (msr_psr_rm),
        .msr_dmmid          (msr_dmmid),
        .msr_dmm_tlbl_idx   (tlbl_idx),
        .msr_dmm_tlbl_nxt   (tlbl_nxt),
        .msr_dmm_tlbl_we    (tlbl_we),
        .msr_dmm_tlbl       (msr_dmm_tlbl),
        .msr_dmm_tlbh_idx   (tlbh_idx),
        .msr_dmm_tlbh_nxt   (tlbh_nxt),
        .msr_dmm_tlbh_we    (tlbh_we),
        .msr_dmm_tlbh       (msr_dmm_tlbh),
        .tlb_flush_req      (tlb_flush_req),
        .tlb_flush_busy     (tlb_flush_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic we);
        dbus.cmd_valid = 1'b1;
        dbus.cmd_addr  = addr;
        dbus.cmd_we    = we;
        tick();
        dbus.cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        dbus.cmd_valid = 0; dbus.cmd_addr = 0; dbus.cmd_size = 3'd2; dbus.cmd_we = 0;
        dbus.cmd_nc = 0; dbus.din = 0; dbus.ready = 0;
        dcache.cmd_ready = 1; dcache.valid = 0; dcache.dout = 0;
        msr_psr_dmme = 0; msr_psr_rm = 0;
        tlbl_idx = 0; tlbl_nxt = 0; tlbl_we = 0;
        tlbh_idx = 0; tlbh_nxt = 0; tlbh_we = 0;
        tlb_flush_req = 0;

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd_valid", {31'b0, dcache.cmd_valid}, 32'd0);
        check("rst_miss", {31'b0, exp_dmm_tlb_miss}, 32'd0);
        check("rst_fault", {31'b0, exp_dmm_page_fault}, 32'd0);
        check("rst_vaddr", exp_dmm_vaddr, 32'd0);
        check("rst_busy", {31'b0, tlb_flush_busy}, 32'd0);
        check("dmmid", msr_dmmid, 32'h0000_000D);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_ready", {31'b0, dbus.cmd_ready}, 32'd1);

        // Response path passes straight through
        dbus.ready = 1; dcache.valid = 1; dcache.dout = 32'hCAFE_F00D;
        #1;
        check("pass_valid", {31'b0, dbus.valid}, 32'd1);
        check("pass_dout", dbus.dout, 32'hCAFE_F00D);
        check("pass_ready", {31'b0, dcache.ready}, 32'd1);
        dbus.ready = 0; dcache.valid = 0;

        // Translation off: address passes untranslated, fields registered
        dbus.din = 32'hDEAD_BEEF;
        dbus.cmd_valid = 1; dbus.cmd_addr = 32'h1234_5678; dbus.cmd_we = 1;
        #1;
        check("bypass_accept_ready", {31'b0, dbus.cmd_ready}, 32'd1);
        issue(32'h1234_5678, 1'b1);
        check("bypass_valid", {31'b0, dcache.cmd_valid}, 32'd1);
        check("bypass_addr", dcache.cmd_addr, 32'h1234_5678);
        check("bypass_size", {29'b0, dcache.cmd_size}, 32'd2);
        check("bypass_we", {31'b0, dcache.cmd_we}, 32'd1);
        check("bypass_din", dcache.din, 32'hDEAD_BEEF);
        check("bypass_nc", {31'b0, dcache.cmd_nc}, 32'd0);
        check("bypass_noexc", {30'b0, exp_dmm_tlb_miss, exp_dmm_page_fault}, 32'd0);
        tick();
        check("bypass_drain", {31'b0, dcache.cmd_valid}, 32'd0);

        // Program way1/set3: VPN 3 valid, PPN 0x70000, UR|NC
        tlbl_idx = 6'h23; tlbl_nxt = 32'h0000_6001; tlbl_we = 1;
        tlbh_idx = 6'h23; tlbh_nxt = 32'hE000_0090; tlbh_we = 1;
        tick();
        tlbl_we = 0; tlbh_we = 0;
        check("msr_read_first", msr_dmm_tlbl, 32'd0);
        tick();
        check("msr_tlbl", msr_dmm_tlbl, 32'h0000_6001);
        check("msr_tlbh", msr_dmm_tlbh, 32'hE000_0090);

        // User load hits way1
        msr_psr_dmme = 1; msr_psr_rm = 0;
        issue(32'h0000_6ABC, 1'b0);
        check("hit_valid", {31'b0, dcache.cmd_valid}, 32'd1);
        check("hit_addr", dcache.cmd_addr, 32'hE000_0ABC);
        check("hit_nc", {31'b0, dcache.cmd_nc}, 32'd1);
        check("hit_noexc", {30'b0, exp_dmm_tlb_miss, exp_dmm_page_fault}, 32'd0);
        tick();

        // User store without UW faults
        issue(32'h0000_6ABC, 1'b1);
        check("ufault_pf", {31'b0, exp_dmm_page_fault}, 32'd1);
        check("ufault_miss", {31'b0, exp_dmm_tlb_miss}, 32'd0);
        check("ufault_valid", {31'b0, dcache.cmd_valid}, 32'd0);
        check("ufault_ready", {31'b0, dbus.cmd_ready}, 32'd1);
        tick();
        check("ufault_pulse", {31'b0, exp_dmm_page_fault}, 32'd0);
        check("ufault_vaddr", exp_dmm_vaddr, 32'h0000_6ABC);

        // Root-mode load without RR faults
        msr_psr_rm = 1;
        issue(32'h0000_6ABC, 1'b0);
        check("rfault_pf", {31'b0, exp_dmm_page_fault}, 32'd1);
        tick();
        msr_psr_rm = 0;

        // Unmapped page misses
        issue(32'h0001_0000, 1'b0);
        check("miss_miss", {31'b0, exp_dmm_tlb_miss}, 32'd1);
        check("miss_pf", {31'b0, exp_dmm_page_fault}, 32'd0);
        check("miss_valid", {31'b0, dcache.cmd_valid}, 32'd0);
        tick();
        check("miss_pulse", {31'b0, exp_dmm_tlb_miss}, 32'd0);
        check("miss_vaddr", exp_dmm_vaddr, 32'h0001_0000);

        // Same VPN in way0 with full permissions: lowest way wins
        tlbl_idx = 6'h03; tlbl_nxt = 32'h0000_6001; tlbl_we = 1;
        tlbh_idx = 6'h03; tlbh_nxt = 32'h0000_2078; tlbh_we = 1;
        tick();
        tlbl_we = 0; tlbh_we = 0;
        issue(32'h0000_6ABC, 1'b1);
        check("multi_valid", {31'b0, dcache.cmd_valid}, 32'd1);
        check("multi_addr", dcache.cmd_addr, 32'h0000_2ABC);
        check("multi_nc", {31'b0, dcache.cmd_nc}, 32'd0);
        check("multi_pf", {31'b0, exp_dmm_page_fault}, 32'd0);
        tick();

        // Back-pressure: stage holds, next command waits, then no bubble
        msr_psr_dmme = 0; dcache.cmd_ready = 0;
        issue(32'h0000_1000, 1'b0);
        dbus.cmd_valid = 1; dbus.cmd_addr = 32'h0000_2000;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'b0, dcache.cmd_valid}, 32'd1);
            check("stall_addr", dcache.cmd_addr, 32'h0000_1000);
            check("stall_ready", {31'b0, dbus.cmd_ready}, 32'd0);
            tick();
        end
        dcache.cmd_ready = 1;
        #1;
        check("stall_release_ready", {31'b0, dbus.cmd_ready}, 32'd1);
        tick();
        dbus.cmd_valid = 0;
        #1;
        check("b2b_valid", {31'b0, dcache.cmd_valid}, 32'd1);
        check("b2b_addr", dcache.cmd_addr, 32'h0000_2000);
        tick();
        check("b2b_drain", {31'b0, dcache.cmd_valid}, 32'd0);

        // Flush: 32 busy cycles, no accepts, MSR write during flush dropped
        tlb_flush_req = 1;
        #1;
        check("flush_req_blocks", {31'b0, dbus.cmd_ready}, 32'd0);
        tick();
        tlb_flush_req = 0;
        n_flush = 0;
        while (tlb_flush_busy === 1'b1 && n_flush < 100) begin
            check("flush_ready", {31'b0, dbus.cmd_ready}, 32'd0);
            if (n_flush == 1) begin
                tlbl_idx = 6'h00; tlbl_nxt = 32'h0000_0001; tlbl_we = 1;
            end else begin
                tlbl_we = 0;
            end
            n_flush++;
            tick();
        end
        tlbl_we = 0;
        check("flush_len", n_flush, 32'd32);
        tick();
        check("flush_msr_dropped", msr_dmm_tlbl, 32'd0);
        tlbl_idx = 6'h23;
        tick();
        check("flush_cleared", msr_dmm_tlbl, 32'd0);
        msr_psr_dmme = 1;
        issue(32'h0000_6ABC, 1'b0);
        check("flush_miss", {31'b0, exp_dmm_tlb_miss}, 32'd1);
        tick();

        // Asynchronous reset while stalled
        msr_psr_dmme = 0; dcache.cmd_ready = 0;
        issue(32'h0000_3000, 1'b0);
        check("arst_setup", {31'b0, dcache.cmd_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, dcache.cmd_valid}, 32'd0);
        check("arst_exc", {30'b0, exp_dmm_tlb_miss, exp_dmm_page_fault}, 32'd0);
        check("arst_vaddr", exp_dmm_vaddr, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
